sha256_block_sequencer: RTL and testbench
=========================================

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-message block counter.
REQ-002 SHALL have parameter SIM_XF_TIMEOUT, default 0: if nonzero, the maximum number of WAIT cycles before xf_timeout is asserted; 0 disables the check.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have ports blk_vld (input, 1) and blk_rdy (output, 1): upstream 512-bit block handshake.
REQ-006 SHALL have port blk_data, input, [15:0][31:0]: message block; word 0 is the first big-endian word.
REQ-007 SHALL have ports blk_first and blk_last, input, 1 each: message delimiters, qualified by blk_vld.
REQ-008 SHALL have ports xf_ctx_vld (output, 1), xf_ctx_rdy (input, 1) and xf_ctx (output, sha256_pkg::ShaContext): context issue to the transform; word 0 = a/H0 through word 7 = h/H7.
REQ-009 SHALL have ports xf_chunk_vld (output, 1), xf_chunk_rdy (input, 1) and xf_chunk (output, [15:0][31:0]): chunk issue to the transform.
REQ-010 SHALL have ports xf_out_vld (input, 1), xf_out_rdy (output, 1) and xf_out (input, ShaContext): compressed working variables a..h from the transform, without feed-forward.
REQ-011 SHALL have ports digest_vld (output, 1), digest_rdy (input, 1) and digest (output, ShaContext): final hash of a message.
REQ-012 SHALL have port blk_count, output, CNT_W: number of blocks in the message, valid with digest_vld.
REQ-013 SHALL have ports proto_err and xf_timeout, output, 1: proto_err is a single-cycle pulse; xf_timeout is sticky until reset.

Function
REQ-014 FSM states SHALL be IDLE, MID, ISSUE, WAIT and DONE, one-hot or encoded.
REQ-015 blk_rdy SHALL be 1 only in IDLE and MID; a block is accepted when blk_vld and blk_rdy are both 1.
REQ-016 On accept in IDLE: H SHALL load the FIPS 180-4 IV (6a09e667 .. 5be0cd19), blk_count SHALL become 1, and blk_first SHALL be ignored (block treated as first).
REQ-017 On accept in MID with blk_first=0: H SHALL be retained and blk_count SHALL increment, wrapping modulo 2^CNT_W.
REQ-018 On accept in MID with blk_first=1: proto_err SHALL pulse for 1 cycle, H SHALL reload the IV, blk_count SHALL become 1, and the partial message SHALL be discarded.
REQ-019 An accepted block SHALL register blk_data and blk_last; next state SHALL be ISSUE.
REQ-020 In ISSUE: xf_ctx_vld=1 with xf_ctx=H, and xf_chunk_vld=1 with the registered chunk, both starting the cycle after accept.
REQ-021 The ctx and chunk handshakes SHALL complete independently; each vld SHALL drop after its own handshake; ISSUE SHALL exit to WAIT in the cycle after both complete (same-cycle completion allowed).
REQ-022 xf_ctx and xf_chunk SHALL be stable while their vld is high and unaccepted.
REQ-023 In WAIT: xf_out_rdy=1, and xf_out_rdy SHALL be 0 in every other state.
REQ-024 On the xf_out handshake: H[i] SHALL become (H[i] + xf_out[i]) mod 2^32 for i=0..7, registered.
REQ-025 After the xf_out handshake, next state SHALL be DONE if the registered last=1, else MID.
REQ-026 DONE: digest_vld=1 with digest=H and blk_count held stable; on digest_rdy, next state SHALL be IDLE.
REQ-027 Latency: result handshake at cycle r SHALL give digest_vld at r+1; block accept at t SHALL give xf vld at t+1.
REQ-028 At most one block SHALL be in flight; no new block is accepted outside IDLE/MID.
REQ-029 xf_out_vld outside WAIT SHALL be ignored (rdy=0).
REQ-030 If SIM_XF_TIMEOUT>0 and WAIT persists for more than SIM_XF_TIMEOUT cycles, xf_timeout SHALL set; the FSM SHALL keep waiting.

Reset
REQ-031 While rst=0 at a clk edge: state=IDLE; blk_rdy, xf_ctx_vld, xf_chunk_vld, xf_out_rdy, digest_vld, proto_err and xf_timeout=0; blk_count=0; H=IV.
REQ-032 Reset mid-operation (any state) SHALL abandon the message without emitting a digest; rdy/vld outputs SHALL be 0 in the first cycle after release, then blk_rdy=1.

Verification
REQ-033 Single block "abc" (padded, first=last=1) with a 1-cycle transform model -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, blk_count=1.
REQ-034 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, blk_count=2; the second xf_ctx equals the first-block intermediate H.
REQ-035 xf_chunk_rdy delayed 3 cycles after xf_ctx_rdy, with digest_rdy held low 5 cycles -> same "abc" digest; vld/data stable throughout the stalls.
REQ-036 blk_first=1 on the second block of an unfinished message -> proto_err pulses once; the following single block "abc" -> the "abc" digest.
REQ-037 rst=0 asserted in WAIT, with a stale xf_out_vld after release -> no digest_vld; stale xf_out ignored; the next "abc" message -> the correct digest.
REQ-038 Back-to-back messages with no idle cycles -> digests in order, and blk_rdy low from accept until MID/IDLE.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
// Sequences 512-bit blocks through an external SHA-256 compression core,
// holding the chaining value H and emitting the final digest per message.
module sha256_block_sequencer #(
  parameter int CNT_W          = 16,
  parameter int SIM_XF_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blk_vld,
  output logic                   blk_rdy,
  input  logic [15:0][31:0]      blk_data,
  input  logic                   blk_first,
  input  logic                   blk_last,
  output logic                   xf_ctx_vld,
  input  logic                   xf_ctx_rdy,
  output logic [7:0][31:0]       xf_ctx,
  output logic                   xf_chunk_vld,
  input  logic                   xf_chunk_rdy,
  output logic [15:0][31:0]      xf_chunk,
  input  logic                   xf_out_vld,
  output logic                   xf_out_rdy,
  input  logic [7:0][31:0]       xf_out,
  output logic                   digest_vld,
  input  logic                   digest_rdy,
  output logic [7:0][31:0]       digest,
  output logic [CNT_W-1:0]       blk_count,
  output logic                   proto_err,
  output logic                   xf_timeout
);

  // Context words are packed with word 0 = a/H0 in the low 32 bits.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {IDLE, MID, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0][31:0]  h_q, h_d;
  logic [15:0][31:0] chunk_q, chunk_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctx_done_q, ctx_done_d;
  logic              chunk_done_q, chunk_done_d;
  logic              proto_q, proto_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       wait_q, wait_d;
  logic [1:0]        live_q;
  logic [31:0]       h_sum [8];
  logic              blk_acc, ctx_hs, chunk_hs, out_hs;

  // Feed-forward adders: the core returns a..h without the chaining add.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ff
      assign h_sum[gi] = h_q[gi] + xf_out[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      h_q          <= SHA256_IV;
      chunk_q      <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      ctx_done_q   <= 1'b0;
      chunk_done_q <= 1'b0;
      proto_q      <= 1'b0;
      tmo_q        <= 1'b0;
      wait_q       <= '0;
      live_q       <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      chunk_q      <= chunk_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ctx_done_q   <= ctx_done_d;
      chunk_done_q <= chunk_done_d;
      proto_q      <= proto_d;
      tmo_q        <= tmo_d;
      wait_q       <= wait_d;
      live_q       <= {live_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    chunk_d      = chunk_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ctx_done_d   = ctx_done_q;
    chunk_done_d = chunk_done_q;
    proto_d      = 1'b0;
    tmo_d        = tmo_q;
    wait_d       = '0;

    // live_q keeps blk_rdy low for one full cycle after reset release.
    blk_rdy      = live_q[1] && (state_q == IDLE || state_q == MID);
    xf_ctx_vld   = (state_q == ISSUE) && !ctx_done_q;
    xf_chunk_vld = (state_q == ISSUE) && !chunk_done_q;
    xf_out_rdy   = (state_q == WAIT);
    digest_vld   = (state_q == DONE);

    blk_acc  = blk_vld && blk_rdy;
    ctx_hs   = xf_ctx_vld && xf_ctx_rdy;
    chunk_hs = xf_chunk_vld && xf_chunk_rdy;
    out_hs   = xf_out_vld && xf_out_rdy;

    unique case (state_q)
      IDLE, MID: begin
        if (blk_acc) begin
          chunk_d      = blk_data;
          last_d       = blk_last;
          ctx_done_d   = 1'b0;
          chunk_done_d = 1'b0;
          state_d      = ISSUE;
          if (state_q == IDLE || blk_first) begin
            h_d     = SHA256_IV;
            cnt_d   = CNT_W'(1);
            proto_d = (state_q == MID);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        if (ctx_hs) ctx_done_d = 1'b1;
        if (chunk_hs) chunk_done_d = 1'b1;
        if ((ctx_done_q || ctx_hs) && (chunk_done_q || chunk_hs)) state_d = WAIT;
      end
      WAIT: begin
        wait_d = (wait_q == '1) ? wait_q : wait_q + 32'd1;
        if (SIM_XF_TIMEOUT != 0 && wait_q >= 32'(SIM_XF_TIMEOUT)) tmo_d = 1'b1;
        if (out_hs) begin
          for (int i = 0; i < 8; i++) h_d[i] = h_sum[i];
          state_d = last_q ? DONE : MID;
        end
      end
      DONE: begin
        if (digest_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xf_ctx     = h_q;
  assign xf_chunk   = chunk_q;
  assign digest     = h_q;
  assign blk_count  = cnt_q;
  assign proto_err  = proto_q;
  assign xf_timeout = tmo_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Randomized bench for sha256_block_sequencer: plays the compression core and
// digest sink, and checks digests against a software SHA-256 model.
`timescale 1ns/1ps
module tb_sha256_block_sequencer;
  typedef logic [7:0][31:0]  ctx_t;
  typedef logic [15:0][31:0] blk_t;
  localparam int CNT_W = 3;
  localparam int TMO   = 20;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam ctx_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                         32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam ctx_t ABC = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                          32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam ctx_t TWO = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                          32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic blk_vld = 1'b0, blk_rdy, blk_first = 1'b0, blk_last = 1'b0;
  blk_t blk_data = '0;
  logic xf_ctx_vld, xf_ctx_rdy, xf_chunk_vld, xf_chunk_rdy, xf_out_vld, xf_out_rdy;
  ctx_t xf_ctx, xf_out, digest;
  blk_t xf_chunk;
  logic digest_vld, digest_rdy, proto_err, xf_timeout;
  logic [CNT_W-1:0] blk_count;

  always #5 clk = ~clk;

  sha256_block_sequencer #(.CNT_W(CNT_W), .SIM_XF_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .xf_ctx_vld(xf_ctx_vld), .xf_ctx_rdy(xf_ctx_rdy), .xf_ctx(xf_ctx),
    .xf_chunk_vld(xf_chunk_vld), .xf_chunk_rdy(xf_chunk_rdy), .xf_chunk(xf_chunk),
    .xf_out_vld(xf_out_vld), .xf_out_rdy(xf_out_rdy), .xf_out(xf_out),
    .digest_vld(digest_vld), .digest_rdy(digest_rdy), .digest(digest),
    .blk_count(blk_count), .proto_err(proto_err), .xf_timeout(xf_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- SHA-256 reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic ctx_t compress(input ctx_t h, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    ctx_t r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  blk_t msg_q [$];

  function automatic ctx_t model_hash(input int upto);
    ctx_t h = IV;
    ctx_t c;
    for (int b = 0; b < upto; b++) begin
      c = compress(h, msg_q[b]);
      for (int i = 0; i < 8; i++) h[i] = h[i] + c[i];
    end
    return h;
  endfunction

  task automatic pad_msg(input string s);
    byte unsigned by [$];
    longint unsigned bits;
    blk_t b;
    bits = 64'(s.len()) * 64'd8;
    for (int i = 0; i < s.len(); i++) by.push_back(s[i]);
    by.push_back(8'h80);
    while (by.size() % 64 != 56) by.push_back(8'h00);
    for (int i = 7; i >= 0; i--) by.push_back(8'(bits >> (8 * i)));
    msg_q.delete();
    for (int k = 0; k < by.size() / 64; k++) begin
      for (int j = 0; j < 16; j++)
        b[j] = {by[k*64+4*j], by[k*64+4*j+1], by[k*64+4*j+2], by[k*64+4*j+3]};
      msg_q.push_back(b);
    end
  endtask

  task automatic rand_msg(input int n);
    blk_t b;
    msg_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 16; j++) b[j] = $urandom;
      msg_q.push_back(b);
    end
  endtask

  // ---------------- transform core responder ----------------
  int   ctx_dly = 0, chunk_dly = 0, out_dly = 0, dig_dly = 0;
  bit   stale_vld = 1'b0;
  bit   ctx_hs, chunk_hs, out_busy;
  int   ctx_age, chunk_age, out_age;
  ctx_t ctx_cap, out_res;
  blk_t chunk_cap;
  ctx_t ctx_log [$];

  initial begin
    xf_ctx_rdy = 1'b0; xf_chunk_rdy = 1'b0; xf_out_vld = 1'b0; xf_out = '0;
    ctx_hs = 0; chunk_hs = 0; out_busy = 0; ctx_age = 0; chunk_age = 0; out_age = 0;
    out_res = '0;
    forever begin
      @(negedge clk);
      xf_ctx_rdy   = 1'b0;
      xf_chunk_rdy = 1'b0;
      xf_out_vld   = stale_vld;
      xf_out       = stale_vld ? ~IV : out_res;
      if (!rst) begin
        ctx_hs = 0; chunk_hs = 0; out_busy = 0; ctx_age = 0; chunk_age = 0; out_age = 0;
      end else begin
        if (xf_ctx_vld) begin
          if (ctx_hs) check_eq("ctx_vld_drop", xf_ctx_vld, 0);
          else begin
            if (ctx_age == 0) ctx_cap = xf_ctx;
            else check_eq("ctx_stable", xf_ctx, ctx_cap);
            if (ctx_age >= ctx_dly) begin xf_ctx_rdy = 1'b1; ctx_hs = 1; end
            ctx_age++;
          end
        end
        if (xf_chunk_vld) begin
          if (chunk_hs) check_eq("chunk_vld_drop", xf_chunk_vld, 0);
          else begin
            if (chunk_age == 0) chunk_cap = xf_chunk;
            else check_eq("chunk_stable", xf_chunk, chunk_cap);
            if (chunk_age >= chunk_dly) begin xf_chunk_rdy = 1'b1; chunk_hs = 1; end
            chunk_age++;
          end
        end
        if (ctx_hs && chunk_hs) begin
          if (!out_busy) begin
            out_busy = 1; out_age = 0;
            out_res  = compress(ctx_cap, chunk_cap);
            ctx_log.push_back(ctx_cap);
          end
          if (out_age >= out_dly) begin
            xf_out_vld = 1'b1;
            xf_out     = out_res;
            if (xf_out_rdy) begin
              ctx_hs = 0; chunk_hs = 0; out_busy = 0; ctx_age = 0; chunk_age = 0;
            end
          end
          out_age++;
        end
      end
    end
  end

  // ---------------- digest sink ----------------
  ctx_t             exp_dig [$];
  logic [CNT_W-1:0] exp_cnt [$];
  int               dig_age = 0, dig_vld_cycles = 0, proto_cnt = 0;
  ctx_t             dig_cap;
  logic [CNT_W-1:0] cnt_cap;

  initial begin
    digest_rdy = 1'b0;
    forever begin
      @(negedge clk);
      digest_rdy = 1'b0;
      if (!rst) dig_age = 0;
      else begin
        if (proto_err) proto_cnt++;
        if (digest_vld) begin
          dig_vld_cycles++;
          if (dig_age == 0) begin dig_cap = digest; cnt_cap = blk_count; end
          else begin
            check_eq("digest_stable", digest, dig_cap);
            check_eq("count_stable", blk_count, cnt_cap);
          end
          if (dig_age >= dig_dly) begin
            digest_rdy = 1'b1;
            dig_age = 0;
            check_eq("digest_expected", exp_dig.size() > 0, 1);
            if (exp_dig.size() > 0) begin
              $display("digest %h count %0d", digest, blk_count);
              check_eq("digest", digest, exp_dig.pop_front());
              check_eq("blk_count", blk_count, exp_cnt.pop_front());
            end
          end else dig_age++;
        end
      end
    end
  end

  // ---------------- upstream driver ----------------
  task automatic send_blk(input blk_t d, input bit f, input bit l);
    int n = 0;
    blk_vld = 1'b1; blk_data = d; blk_first = f; blk_last = l;
    while (!blk_rdy && n < 500) begin @(negedge clk); n++; end
    if (!blk_rdy) begin
      check_eq("blk_accept_timeout", blk_rdy, 1);
      blk_vld = 1'b0;
      return;
    end
    @(negedge clk);
    check_eq("blk_rdy_low_after_accept", blk_rdy, 0);
    check_eq("xf_vld_after_accept", {xf_ctx_vld, xf_chunk_vld}, 2'b11);
  endtask

  task automatic send_msg(input ctx_t exp_d, input bit keep);
    int n = msg_q.size();
    exp_dig.push_back(exp_d);
    exp_cnt.push_back(CNT_W'(n));
    for (int i = 0; i < n; i++) send_blk(msg_q[i], i == 0, i == n - 1);
    if (!keep) blk_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_dig.size() != 0 || !blk_rdy) && n < 3000) begin @(negedge clk); n++; end
    check_eq("drain", exp_dig.size(), 0);
  endtask

  task automatic set_dly(input int c, input int k, input int o, input int d);
    ctx_dly = c; chunk_dly = k; out_dly = o; dig_dly = d;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {blk_rdy, xf_ctx_vld, xf_chunk_vld, xf_out_rdy,
                               digest_vld, proto_err, xf_timeout}, 7'b0);
    check_eq("reset_blk_count", blk_count, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rdy_first_cycle_after_release", blk_rdy, 0);
    @(negedge clk);
    check_eq("rdy_after_release", blk_rdy, 1);

    // Single-block "abc"
    set_dly(0, 0, 0, 0);
    pad_msg("abc");
    send_msg(ABC, 1'b0);
    wait_drain();

    // Two-block message; second ctx must be the intermediate H
    ctx_log.delete();
    pad_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(TWO, 1'b0);
    wait_drain();
    check_eq("ctx_log_size", ctx_log.size(), 2);
    check_eq("ctx_blk0", ctx_log[0], IV);
    check_eq("ctx_blk1", ctx_log[1], model_hash(1));

    // Chunk accepted 3 cycles after ctx, digest held 5 cycles
    set_dly(0, 3, 1, 5);
    pad_msg("abc");
    send_msg(ABC, 1'b0);
    wait_drain();

    // blk_first on the second block of an unfinished message
    set_dly(0, 0, 0, 0);
    base = proto_cnt;
    rand_msg(1);
    send_blk(msg_q[0], 1'b1, 1'b0);
    pad_msg("abc");
    exp_dig.push_back(ABC);
    exp_cnt.push_back(CNT_W'(1));
    send_blk(msg_q[0], 1'b1, 1'b1);
    blk_vld = 1'b0;
    wait_drain();
    check_eq("proto_err_pulses", proto_cnt - base, 1);

    // Back-to-back random messages; a 9-block one wraps the 3-bit counter
    base = proto_cnt;
    for (int m = 0; m < 6; m++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rand_msg(m == 2 ? 9 : int'($urandom_range(1, 4)));
      send_msg(model_hash(msg_q.size()), 1'b1);
    end
    blk_vld = 1'b0;
    wait_drain();
    check_eq("no_proto_err_b2b", proto_cnt - base, 0);
    check_eq("timeout_clear", xf_timeout, 0);

    // Timeout boundary: exactly TMO cycles in WAIT is fine, one more sets it
    set_dly(0, 0, TMO, 0);
    rand_msg(1);
    send_msg(model_hash(1), 1'b0);
    wait_drain();
    check_eq("timeout_at_limit", xf_timeout, 0);
    set_dly(0, 0, TMO + 1, 0);
    rand_msg(2);
    send_msg(model_hash(2), 1'b0);
    wait_drain();
    check_eq("timeout_past_limit", xf_timeout, 1);

    // Reset while in WAIT, stale xf_out_vld afterwards
    set_dly(0, 0, 10, 0);
    pad_msg("abc");
    send_blk(msg_q[0], 1'b1, 1'b1);
    blk_vld = 1'b0;
    n = 0;
    while (!xf_out_rdy && n < 100) begin @(negedge clk); n++; end
    check_eq("reached_wait", xf_out_rdy, 1);
    rst = 1'b0;
    base = dig_vld_cycles;
    repeat (2) @(negedge clk);
    check_eq("midop_reset_outputs", {blk_rdy, xf_ctx_vld, xf_chunk_vld, xf_out_rdy,
                                     digest_vld, proto_err, xf_timeout}, 7'b0);
    check_eq("midop_reset_count", blk_count, 0);
    rst = 1'b1;
    stale_vld = 1'b1;
    @(negedge clk);
    check_eq("midop_rdy_first_cycle", blk_rdy, 0);
    @(negedge clk);
    check_eq("midop_rdy_after", blk_rdy, 1);
    repeat (6) @(negedge clk);
    check_eq("stale_out_ignored", {xf_out_rdy, digest_vld, blk_rdy}, 3'b001);
    stale_vld = 1'b0;
    check_eq("no_digest_after_reset", dig_vld_cycles - base, 0);
    set_dly(0, 0, 0, 0);
    pad_msg("abc");
    send_msg(ABC, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
